// File: rtl/pipe_pkg.sv
// Shared layout for the memory stage: EX/MEM bundle field offsets, MEM/WB layout, FSM state.
package pipe_pkg;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam int RC_W  = 4;
    localparam int OPC_W = 4;
    localparam int OPT_W = 2;

    // EX/MEM bundle, LSB upward: rd3, Rc, Rb, Ra, regWrite, memToReg, memWrite,
    // branchFlag, negFlag, zeroFlag, aluResult, opCode, opType
    function automatic int rc_lsb(int n);      return n;          endfunction
    function automatic int rw_bit(int n);      return n + 12;     endfunction
    function automatic int mtr_bit(int n);     return n + 13;     endfunction
    function automatic int mw_bit(int n);      return n + 14;     endfunction
    function automatic int br_bit(int n);      return n + 15;     endfunction
    function automatic int zero_bit(int n);    return n + 17;     endfunction
    function automatic int alu_lsb(int n);     return n + 18;     endfunction
    function automatic int opc_lsb(int n);     return 2 * n + 18; endfunction
    function automatic int opt_lsb(int n);     return 2 * n + 22; endfunction
    function automatic int bundle_w(int n);    return 2 * n + 24; endfunction

    // MEM/WB word, LSB upward: Rc, regWrite, memToReg, aluResult, memData, opCode, opType
    localparam int WB_RW_BIT = 4;
    function automatic int wb_w(int n);        return 2 * n + 12; endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface mem_access_if #(
    parameter int N = 4
) ();
    logic         memReq;
    logic         memWe;
    logic [N-1:0] memAddr;
    logic [N-1:0] memWData;
    logic         memAck;
    logic [N-1:0] memRData;

    modport master (output memReq, memWe, memAddr, memWData, input memAck, memRData);
    modport slave  (input memReq, memWe, memAddr, memWData, output memAck, memRData);
endinterface

// File: rtl/access_timer.sv
// Counts ACCESS cycles; o_expired flags the cycle that is the TIMEOUT-th one.
module access_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
    end

    // r_cnt holds completed cycles, so the current cycle number is r_cnt+1
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: passes ALU ops straight to MEM/WB, runs loads/stores over a
// request/ack bus with a timeout abort that suppresses the register write.
module mem_access
    import pipe_pkg::*;
#(
    parameter int N       = 4,
    parameter int BW      = 82,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 validIn,
    input  logic [BW-1:0]        bundleIn,
    mem_access_if.master         mem,
    output logic                 stall,
    output logic                 pcSrc,
    output logic                 memErr,
    output logic                 wbValid,
    output logic [wb_w(N)-1:0]   wbOut
);
    localparam int LO_W = N + 6;

    logic [OPT_W-1:0] w_opType;
    logic [OPC_W-1:0] w_opCode;
    logic [N-1:0]     w_alu, w_rd3, w_memData;
    logic [RC_W-1:0]  w_rc;
    logic             w_zero, w_br, w_mw, w_mtr, w_rw, w_expired, w_unused;

    assign w_opType = bundleIn[opt_lsb(N) +: OPT_W];
    assign w_opCode = bundleIn[opc_lsb(N) +: OPC_W];
    assign w_alu    = bundleIn[alu_lsb(N) +: N];
    assign w_zero   = bundleIn[zero_bit(N)];
    assign w_br     = bundleIn[br_bit(N)];
    assign w_mw     = bundleIn[mw_bit(N)];
    assign w_mtr    = bundleIn[mtr_bit(N)];
    assign w_rw     = bundleIn[rw_bit(N)];
    assign w_rc     = bundleIn[rc_lsb(N) +: RC_W];
    assign w_rd3    = bundleIn[N-1:0];
    assign w_unused = ^bundleIn;

    state_t                   r_state;
    logic                     r_memReq, r_memWe, r_memErr, r_wbValid;
    logic [N-1:0]             r_memAddr, r_memWData;
    logic [OPT_W+OPC_W-1:0]   r_latHi;
    logic [LO_W-1:0]          r_latLo;
    logic [wb_w(N)-1:0]       r_wbOut;

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == IDLE),
        .i_en      (r_state == ACCESS),
        .o_expired (w_expired)
    );

    // Stores (including memWrite&memToReg) write back zero rather than bus data
    assign w_memData = r_memWe ? '0 : mem.memRData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_memErr   <= 1'b0;
            r_wbValid  <= 1'b0;
            r_wbOut    <= '0;
            r_latHi    <= '0;
            r_latLo    <= '0;
        end else begin
            case (r_state)
                IDLE: if (en) begin
                    if (validIn && !flush) begin
                        if (w_mw || w_mtr) begin
                            r_latHi    <= {w_opType, w_opCode};
                            r_latLo    <= {w_alu, w_mtr, w_rw, w_rc};
                            r_memReq   <= 1'b1;
                            r_memWe    <= w_mw;
                            r_memAddr  <= w_alu;
                            r_memWData <= w_rd3;
                            r_wbValid  <= 1'b0;
                            r_state    <= ACCESS;
                        end else begin
                            r_wbOut   <= {w_opType, w_opCode, {N{1'b0}}, w_alu, w_mtr, w_rw, w_rc};
                            r_wbValid <= 1'b1;
                        end
                    end else begin
                        r_wbValid <= 1'b0;
                    end
                end
                ACCESS: if (mem.memAck || w_expired) begin
                    r_state    <= IDLE;
                    r_memReq   <= 1'b0;
                    r_memWe    <= 1'b0;
                    r_memAddr  <= '0;
                    r_memWData <= '0;
                    r_wbValid  <= 1'b1;
                    if (mem.memAck) begin
                        r_wbOut <= {r_latHi, w_memData, r_latLo};
                    end else begin
                        // aborted access: deliver the slot but never write the register file
                        r_wbOut  <= {r_latHi, {N{1'b0}}, r_latLo[LO_W-1:WB_RW_BIT+1], 1'b0, r_latLo[RC_W-1:0]};
                        r_memErr <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.memReq   = r_memReq;
    assign mem.memWe    = r_memWe;
    assign mem.memAddr  = r_memAddr;
    assign mem.memWData = r_memWData;

    assign stall   = (r_state == ACCESS) && !mem.memAck && !w_expired;
    assign pcSrc   = validIn && w_br && w_zero && !flush;
    assign memErr  = r_memErr;
    assign wbValid = r_wbValid;
    assign wbOut   = r_wbOut;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table for single-cycle behaviour, hand sequences
// for load, store, timeout and mid-access reset.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, flush = 1'b0, validIn = 1'b0;
    logic [81:0] bundleIn = '0;
    logic        stall, pcSrc, memErr, wbValid;
    logic [19:0] wbOut;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_access_if #(.N(4)) mif ();

    mem_access #(.N(4), .BW(82), .TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .validIn  (validIn),
        .bundleIn (bundleIn),
        .mem      (mif.master),
        .stall    (stall),
        .pcSrc    (pcSrc),
        .memErr   (memErr),
        .wbValid  (wbValid),
        .wbOut    (wbOut)
    );

    always #5 clk = ~clk;

    function automatic logic [81:0] bd(input logic [1:0] opt, input logic [3:0] opc,
        input logic [3:0] alu, input logic z, ng, br, mw, mtr, rw,
        input logic [3:0] ra, rb, rc, rd3);
        return {50'd0, opt, opc, alu, z, ng, br, mw, mtr, rw, ra, rb, rc, rd3};
    endfunction

    function automatic logic [19:0] wb(input logic [1:0] opt, input logic [3:0] opc,
        input logic [3:0] md, alu, input logic mtr, rw, input logic [3:0] rc);
        return {opt, opc, md, alu, mtr, rw, rc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en, flush, valid;
        logic [81:0] b;
        logic        e_pc, e_vld, chk_out;
        logic [19:0] e_out;
    } vec_t;

    vec_t vt[9];

    initial begin
        mif.memAck   = 1'b0;
        mif.memRData = '0;

        vt[0] = '{1, 0, 1, bd(1, 2, 9, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0), 0, 1, 1, wb(1, 2, 0, 9, 0, 1, 3)};
        vt[1] = '{0, 0, 1, bd(1, 3, 5, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), 0, 1, 1, wb(1, 2, 0, 9, 0, 1, 3)};
        vt[2] = '{1, 0, 0, bd(1, 3, 5, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), 0, 0, 0, '0};
        vt[3] = '{1, 1, 1, bd(2, 4'hB, 6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, '0};
        vt[4] = '{1, 0, 1, bd(2, 4'hB, 6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, wb(2, 4'hB, 0, 6, 0, 0, 0)};
        vt[5] = '{1, 0, 1, bd(3, 4'hF, 4'hF, 1, 1, 0, 0, 0, 1, 4'hA, 4'hB, 4'hF, 4'hC), 0, 1, 1,
                  wb(3, 4'hF, 0, 4'hF, 0, 1, 4'hF)};
        vt[6] = '{1, 0, 1, bd(2, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 1, wb(2, 8, 0, 1, 0, 0, 0)};
        vt[7] = '{0, 0, 1, bd(2, 9, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, wb(2, 8, 0, 1, 0, 0, 0)};
        vt[8] = '{1, 0, 0, bd(2, 9, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, '0};

        // reset state
        #3;
        chk("rst_wbValid", wbValid, 0);
        chk("rst_wbOut", wbOut, 0);
        chk("rst_memReq", mif.memReq, 0);
        chk("rst_memErr", memErr, 0);
        chk("rst_stall", stall, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        foreach (vt[i]) begin
            en = vt[i].en; flush = vt[i].flush; validIn = vt[i].valid; bundleIn = vt[i].b;
            #1;
            chk($sformatf("v%0d_pcSrc", i), pcSrc, vt[i].e_pc);
            chk($sformatf("v%0d_stall", i), stall, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wbValid", i), wbValid, vt[i].e_vld);
            chk($sformatf("v%0d_memReq", i), mif.memReq, 0);
            if (vt[i].chk_out) chk($sformatf("v%0d_wbOut", i), wbOut, vt[i].e_out);
        end

        // memAck while idle does nothing
        en = 1; flush = 0; validIn = 0; mif.memAck = 1;
        tick();
        chk("idleack_memReq", mif.memReq, 0);
        chk("idleack_wbValid", wbValid, 0);
        mif.memAck = 0;

        // load: ack in the third ACCESS cycle
        validIn = 1; bundleIn = bd(0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0);
        #1 chk("ld_launch_stall", stall, 0);
        tick();
        validIn = 0; en = 0;
        chk("ld_memWe", mif.memWe, 0);
        chk("ld_memAddr", mif.memAddr, 5);
        chk("ld_wbValid", wbValid, 0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("ld_memReq_c%0d", k), mif.memReq, 1);
            mif.memAck = (k == 3); mif.memRData = (k == 3) ? 4'hA : 4'h3;
            #1 chk($sformatf("ld_stall_c%0d", k), stall, (k != 3));
            tick();
        end
        mif.memAck = 0; en = 1;
        chk("ld_done_memReq", mif.memReq, 0);
        chk("ld_wbValid_done", wbValid, 1);
        chk("ld_wbOut", wbOut, wb(0, 1, 4'hA, 5, 1, 1, 2));
        chk("ld_memErr", memErr, 0);

        // store: immediate ack
        validIn = 1; bundleIn = bd(1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 7);
        tick();
        validIn = 0;
        chk("st_memReq", mif.memReq, 1);
        chk("st_memWe", mif.memWe, 1);
        chk("st_memAddr", mif.memAddr, 2);
        chk("st_memWData", mif.memWData, 7);
        mif.memAck = 1; mif.memRData = 4'hF;
        #1 chk("st_stall", stall, 0);
        tick();
        mif.memAck = 0;
        chk("st_done_memReq", mif.memReq, 0);
        chk("st_done_memWe", mif.memWe, 0);
        chk("st_wbValid", wbValid, 1);
        chk("st_wbOut", wbOut, wb(1, 0, 0, 2, 0, 0, 1));

        // load that never acks: 15 ACCESS cycles then abort
        validIn = 1; bundleIn = bd(0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 4, 0);
        tick();
        validIn = 0;
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("to_memReq_c%0d", k), mif.memReq, 1);
            #1 chk($sformatf("to_stall_c%0d", k), stall, (k < 15));
            tick();
        end
        chk("to_memReq_after", mif.memReq, 0);
        chk("to_memErr", memErr, 1);
        chk("to_wbValid", wbValid, 1);
        chk("to_wbOut", wbOut, wb(0, 3, 0, 3, 1, 0, 4));
        validIn = 1; bundleIn = bd(1, 2, 9, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("to_sticky_%0d", k), memErr, 1);
        end

        // reset in the second ACCESS cycle
        bundleIn = bd(0, 1, 6, 0, 0, 0, 0, 1, 1, 0, 0, 5, 0);
        tick();
        validIn = 0;
        tick();
        chk("rstm_memReq_before", mif.memReq, 1);
        chk("rstm_stall_before", stall, 1);
        rst = 0;
        #1;
        chk("rstm_memReq", mif.memReq, 0);
        chk("rstm_stall", stall, 0);
        chk("rstm_wbValid", wbValid, 0);
        chk("rstm_memErr", memErr, 0);
        tick();
        rst = 1;
        tick();
        chk("rstm_after_memReq", mif.memReq, 0);
        chk("rstm_after_wbValid", wbValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter N, default 4, data/address width.
REQ-002 Parameter BW, default 82, EX/MEM bundle width; fields occupy bits [23+2N:0], upper bits ignored.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles before abort.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  hazard-unit enable; 0 = hold stage in IDLE.
REQ-007 flush  in  1  synchronous discard of the incoming bundle.
REQ-008 validIn  in  1  bundle on bundleIn is a real instruction.
REQ-009 bundleIn  in  BW  EX/MEM bundle, MSB->LSB: opType[2], opCode[4], aluResult[N], zeroFlag, negFlag, branchFlag, memWrite, memToReg, regWrite, Ra[4], Rb[4], Rc[4], rd3[N].
REQ-010 memReq/memWe  out  1/1  data-memory request, write strobe.
REQ-011 memAddr/memWData  out  N/N  address (aluResult), store data (rd3).
REQ-012 memAck/memRData  in  1/N  access complete, load data (valid with memAck).
REQ-013 stall  out  1  upstream must hold bundleIn.
REQ-014 pcSrc  out  1  branch taken, combinational from bundleIn: validIn & branchFlag & zeroFlag & ~flush.
REQ-015 memErr  out  1  sticky timeout flag.
REQ-016 wbValid  out  1  MEM/WB register holds a valid instruction.
REQ-017 wbOut  out  12+2N  MEM/WB register, MSB->LSB: opType, opCode, memData[N], aluResult[N], memToReg, regWrite, Rc.

Function
REQ-018 FSM states IDLE, ACCESS; registered; ACCESS drives memReq=1 and latched memWe/memAddr/memWData, IDLE drives all memory outputs 0.
REQ-019 IDLE, en=1, validIn=1, flush=0, memWrite=0, memToReg=0: wbOut/wbValid=1 loaded next edge, memData=0 (latency 1).
REQ-020 IDLE, en=1, validIn=1, flush=0, memWrite|memToReg: bundle latched, wbValid=0 next edge, state -> ACCESS; stall=0 in this cycle.
REQ-021 IDLE with en=0: wbOut, wbValid held; no capture.
REQ-022 IDLE with flush=1 or validIn=0 (en=1): wbValid=0 next edge, no access.
REQ-023 ACCESS: stall = ~memAck (combinational); memAck=1 -> wbOut loaded from latch with memData=memRData (0 for stores), wbValid=1, state -> IDLE.
REQ-024 ACCESS ignores en and flush; a started access always completes or times out.
REQ-025 Timer counts ACCESS cycles from 1; memAck not seen in cycle TIMEOUT -> state -> IDLE, memErr=1, wbValid=1 with regWrite forced 0, stall=0 in that cycle.
REQ-026 memAck in the TIMEOUT cycle is a normal completion, no error.
REQ-027 memAck while IDLE ignored.
REQ-028 memErr cleared only by reset.
REQ-029 memWe=1 only for memWrite; memWrite&memToReg both set treated as store.

Reset
REQ-030 rst=0 asynchronously: state=IDLE, timer=0, wbOut=0, wbValid=0, memErr=0, memReq=0, memWe=0, memAddr=0, memWData=0.
REQ-031 Reset mid-ACCESS abandons access, no memErr; memReq drops immediately.

Structure
REQ-032 Package pipe_pkg holds bundle field offsets/widths (functions of N), MEM/WB layout, FSM state enum.
REQ-033 One sub-module access_timer: counter with clear, enable, expired output at TIMEOUT.

Verification
REQ-034 ALU op aluResult=4'h9, regWrite=1, Rc=3 -> next cycle wbValid=1, aluResult=9, memData=0, Rc=3, stall never 1.
REQ-035 Load addr 4'h5, memAck after 3 ACCESS cycles with memRData=4'hA -> memReq 3 cycles, stall 1,1,0, then wbOut memData=A, memToReg=1.
REQ-036 Store addr 4'h2 rd3=4'h7, immediate ack -> memWe=1, memAddr=2, memWData=7 one cycle, wbValid=1 regWrite=0.
REQ-037 Load, no memAck -> 15 ACCESS cycles, then memErr=1, wbValid=1, regWrite=0; memErr stays 1 over next 20 cycles.
REQ-038 rst=0 in 2nd ACCESS cycle -> memReq, stall, wbValid 0 same cycle; memErr=0.
REQ-039 Branch bundle branchFlag=1 zeroFlag=1 with flush=1 -> pcSrc=0, wbValid=0; flush=0 -> pcSrc=1.
